// File: rtl/rs_dispatch_pkg.sv
// ============================================================================
// Module      : rs_dispatch_pkg
// Description : Shared types and constants for the RS dispatch slice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package rs_dispatch_pkg;

  localparam int C_NUM_ALU   = 5;
  localparam int C_PAYLOAD_W = 96;

  typedef enum logic [1:0] {
    CLASS_ALU  = 2'd0,
    CLASS_CMP  = 2'd1,
    CLASS_BR   = 2'd2,
    CLASS_LDST = 2'd3
  } iq_class_e;

  typedef struct packed {
    logic [C_NUM_ALU-1:0]   alu_valid;
    logic                   cmp_valid;
    logic                   br_valid;
    logic                   ldst_valid;
    logic                   slot;
    logic [C_PAYLOAD_W-1:0] payload;
  } disp_bundle_t;

endpackage

`default_nettype wire

// File: rtl/rs_dispatch_rr_unit_select.sv
// ============================================================================
// Module      : rr_unit_select
// Description : Round-robin first-free search over two-entry ALU units.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_unit_select
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = C_NUM_ALU,
  parameter int PTR_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic [2*NUM_UNITS-1:0] free_i,
  input  logic [PTR_W-1:0]       ptr_i,
  output logic [NUM_UNITS-1:0]   unit_oh_o,
  output logic                   entry_o,
  output logic                   found_o
);

  always_comb begin
    int idx;
    unit_oh_o = '0;
    entry_o   = 1'b0;
    found_o   = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (!found_o && (free_i[2*idx] || free_i[2*idx+1])) begin
        found_o        = 1'b1;
        unit_oh_o[idx] = 1'b1;
        // Entry 0 wins whenever it is free.
        entry_o        = ~free_i[2*idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rs_dispatch.sv
// ============================================================================
// Module      : rs_dispatch
// Description : Pops the IQ head into a free RS entry, one registered dispatch per cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rs_dispatch
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_ALU   = C_NUM_ALU,
  parameter int PAYLOAD_W = C_PAYLOAD_W,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iq_valid_i,
  input  logic [1:0]             iq_class_i,
  input  logic [PAYLOAD_W-1:0]   iq_payload_i,
  output logic                   iq_pop_o,
  input  logic                   rob_full_i,
  input  logic                   flush_i,
  input  logic [2*NUM_ALU-1:0]   rs_alu_busy_i,
  input  logic [1:0]             rs_cmp_busy_i,
  input  logic                   rs_br_busy_i,
  input  logic                   rs_ldst_busy_i,
  output logic [NUM_ALU-1:0]     disp_alu_valid_o,
  output logic                   disp_cmp_valid_o,
  output logic                   disp_br_valid_o,
  output logic                   disp_ldst_valid_o,
  output logic                   disp_slot_o,
  output logic [PAYLOAD_W-1:0]   disp_payload_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int PTR_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  disp_bundle_t         disp_q, disp_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [2*NUM_ALU-1:0] w_alu_pend;
  logic [2*NUM_ALU-1:0] w_alu_free;
  logic [1:0]           w_cmp_free;
  logic                 w_br_free;
  logic                 w_ldst_free;
  logic [NUM_ALU-1:0]   w_alu_oh;
  logic                 w_alu_entry;
  logic                 w_alu_found;
  logic [PTR_W-1:0]     w_alu_idx;
  logic                 w_slot_avail;
  logic                 w_pop;
  iq_class_e            w_class;

  // The slot on disp_* is not yet visible in the RS busy bits, so mask it here.
  generate
    for (genvar u = 0; u < NUM_ALU; u++) begin : g_alu_pend
      assign w_alu_pend[2*u]   = disp_q.alu_valid[u] & ~disp_q.slot;
      assign w_alu_pend[2*u+1] = disp_q.alu_valid[u] &  disp_q.slot;
    end
  endgenerate

  assign w_alu_free  = ~(rs_alu_busy_i | w_alu_pend);
  assign w_cmp_free  = ~(rs_cmp_busy_i |
                         {disp_q.cmp_valid & disp_q.slot, disp_q.cmp_valid & ~disp_q.slot});
  assign w_br_free   = ~(rs_br_busy_i | disp_q.br_valid);
  assign w_ldst_free = ~(rs_ldst_busy_i | disp_q.ldst_valid);
  assign w_class     = iq_class_e'(iq_class_i);

  rr_unit_select #(
    .NUM_UNITS (NUM_ALU),
    .PTR_W     (PTR_W)
  ) u_rr_unit_select (
    .free_i    (w_alu_free),
    .ptr_i     (rr_ptr_q),
    .unit_oh_o (w_alu_oh),
    .entry_o   (w_alu_entry),
    .found_o   (w_alu_found)
  );

  always_comb begin
    w_alu_idx = '0;
    for (int u = 0; u < NUM_ALU; u++) begin
      if (w_alu_oh[u]) w_alu_idx = PTR_W'(u);
    end
  end

  always_comb begin
    w_slot_avail = 1'b0;
    case (w_class)
      CLASS_ALU:  w_slot_avail = w_alu_found;
      CLASS_CMP:  w_slot_avail = |w_cmp_free;
      CLASS_BR:   w_slot_avail = w_br_free;
      CLASS_LDST: w_slot_avail = w_ldst_free;
      default:    w_slot_avail = 1'b0;
    endcase
  end

  assign w_pop    = ~rst & (state_q == ST_RUN) & iq_valid_i & ~rob_full_i & ~flush_i & w_slot_avail;
  assign iq_pop_o = w_pop;

  always_comb begin
    state_d        = state_q;
    disp_d         = '0;
    disp_d.payload = disp_q.payload;
    rr_ptr_d       = rr_ptr_q;
    stall_cnt_d    = stall_cnt_q;

    case (state_q)
      ST_RUN:     if (flush_i) state_d = ST_RECOVER;
      ST_RECOVER: state_d = flush_i ? ST_RECOVER : ST_RUN;
      default:    state_d = ST_RUN;
    endcase

    if (w_pop) begin
      disp_d.payload = iq_payload_i;
      case (w_class)
        CLASS_ALU: begin
          disp_d.alu_valid = w_alu_oh;
          disp_d.slot      = w_alu_entry;
          rr_ptr_d         = (w_alu_idx == PTR_W'(NUM_ALU-1)) ? '0 : w_alu_idx + 1'b1;
        end
        CLASS_CMP: begin
          disp_d.cmp_valid = 1'b1;
          disp_d.slot      = ~w_cmp_free[0];
        end
        CLASS_BR:   disp_d.br_valid   = 1'b1;
        CLASS_LDST: disp_d.ldst_valid = 1'b1;
        default:    disp_d.br_valid   = 1'b0;
      endcase
    end

    if (iq_valid_i && !w_pop && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      disp_q      <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      disp_q      <= disp_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign disp_alu_valid_o  = disp_q.alu_valid;
  assign disp_cmp_valid_o  = disp_q.cmp_valid;
  assign disp_br_valid_o   = disp_q.br_valid;
  assign disp_ldst_valid_o = disp_q.ldst_valid;
  assign disp_slot_o       = disp_q.slot;
  assign disp_payload_o    = disp_q.payload;
  assign stall_cnt_o       = stall_cnt_q;

endmodule

`default_nettype wire
